// File: rtl/rv32_bus_arbiter.sv
// Two-port bus arbiter: shares one memory bus between instruction fetch and the
// data port, data-first with a starvation guard, per-grant timeout and withdrawal.
module rv32_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic        instr_fault_out,
    output logic [31:0] instr_read_value_out,

    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_address_in,
    input  logic [31:0] data_write_value_in,
    output logic        data_ready_out,
    output logic        data_fault_out,
    output logic [31:0] data_read_value_out,

    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_address_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in,
    input  logic        bus_fault_in
);

    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

    state_t        state;
    state_t        sel;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] starve_cnt;

    logic data_req;
    logic granted_req;
    logic withdraw;
    logic done;
    logic timeout;
    logic complete;
    logic active;
    logic arb;

    assign data_req = data_read_in | data_write_in;

    always_comb begin
        granted_req = 1'b0;
        case (state)
            INSTR:   granted_req = instr_read_in;
            DATA:    granted_req = data_req;
            default: granted_req = 1'b0;
        endcase
    end

    assign withdraw = (state != IDLE) && !granted_req;
    assign done     = (state != IDLE) && granted_req && bus_ready_in;
    assign timeout  = (state != IDLE) && granted_req && !bus_ready_in &&
                      (wait_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign complete = done | timeout;
    assign active   = (state != IDLE) && granted_req && !timeout;
    assign arb      = (state == IDLE) || complete;

    // Data wins unless instr has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        sel = IDLE;
        if (data_req && (!instr_read_in || starve_cnt < SW'(STARVE_LIMIT)))
            sel = DATA;
        else if (instr_read_in)
            sel = INSTR;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            if (arb)
                state <= sel;
            else if (withdraw)
                state <= IDLE;

            if (arb || withdraw)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;

            if (!instr_read_in || (arb && sel == INSTR))
                starve_cnt <= '0;
            else if (arb && sel == DATA && starve_cnt < SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        bus_read_out         = 1'b0;
        bus_write_out        = 1'b0;
        bus_write_mask_out   = 4'b0;
        bus_address_out      = 32'b0;
        bus_write_value_out  = 32'b0;
        instr_ready_out      = 1'b0;
        instr_fault_out      = 1'b0;
        instr_read_value_out = 32'b0;
        data_ready_out       = 1'b0;
        data_fault_out       = 1'b0;
        data_read_value_out  = 32'b0;

        if (active && state == INSTR) begin
            bus_read_out    = 1'b1;
            bus_address_out = instr_address_in;
        end
        if (active && state == DATA) begin
            bus_read_out        = data_read_in;
            bus_write_out       = data_write_in;
            bus_write_mask_out  = data_write_in ? data_write_mask_in : 4'b0;
            bus_address_out     = data_address_in;
            bus_write_value_out = data_write_value_in;
        end

        // A timeout completes as a fault with no read data.
        if (complete && state == INSTR) begin
            instr_ready_out      = 1'b1;
            instr_fault_out      = done ? bus_fault_in : 1'b1;
            instr_read_value_out = done ? bus_read_value_in : 32'b0;
        end
        if (complete && state == DATA) begin
            data_ready_out      = 1'b1;
            data_fault_out      = done ? bus_fault_in : 1'b1;
            data_read_value_out = done ? bus_read_value_in : 32'b0;
        end
    end

endmodule
